// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op indices, FSM state encoding
// and the per-op latency rule.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_SHR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_ROR   = 4'd6;
    localparam logic [3:0] OP_ROL   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_NEG   = 4'd10;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_INCPC = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of cycles the ALU control line stays asserted for an op.
    function automatic int unsigned op_latency(input logic [3:0] op,
                                               input int unsigned mul_cycles,
                                               input int unsigned div_cycles);
        case (op)
            OP_MUL:  op_latency = mul_cycles;
            OP_DIV:  op_latency = div_cycles;
            default: op_latency = 1;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bus between the control unit (master) and the sequencer (slave).
// start is taken only while busy=0; done stays high until an ack is sampled.
interface alu_seq_if #(
    parameter int BITS = 32
);
    logic            start;
    logic [3:0]      op;
    logic [BITS-1:0] a_in;
    logic [BITS-1:0] b_in;
    logic            ack;
    logic            busy;
    logic            done;
    logic            err;
    logic [BITS-1:0] z_hi;
    logic [BITS-1:0] z_lo;

    modport master (
        output start, op, a_in, b_in, ack,
        input  busy, done, err, z_hi, z_lo
    );

    modport slave (
        input  start, op, a_in, b_in, ack,
        output busy, done, err, z_hi, z_lo
    );
endinterface

// File: rtl/alu_sequencer_decoder.sv
// Combinational op decoder: one-hot ALU control, latency and illegal flag.
module alu_op_decoder
    import alu_seq_pkg::*;
#(
    parameter int SIG_COUNT  = 13,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int LAT_W      = 4
) (
    input  logic [3:0]           op,
    output logic [SIG_COUNT-1:0] ctrl,
    output logic [LAT_W-1:0]     latency,
    output logic                 illegal
);

    always_comb begin
        illegal = (int'(op) >= SIG_COUNT);
        latency = LAT_W'(op_latency(op, MUL_CYCLES, DIV_CYCLES));
        ctrl    = '0;
        if (!illegal) begin
            ctrl = SIG_COUNT'(1) << op;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: latches operands, holds the one-hot ALU control
// for the op's latency, then captures the 64-bit result into Z until acked.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int SIG_COUNT  = 13,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    alu_seq_if.slave             bus,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic [BITS-1:0]      alu_x,
    output logic [BITS-1:0]      alu_y,
    input  logic [2*BITS-1:0]    alu_result,
    output logic [1:0]           state
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int LAT_W   = CNT_W + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_DONE = DONE;

    logic [SIG_COUNT-1:0] dec_ctrl;
    logic [LAT_W-1:0]     dec_latency;
    logic                 dec_illegal;
    logic [SIG_COUNT-1:0] ctrl_q;
    logic [CNT_W-1:0]     cnt;
    logic                 err_q;
    logic [BITS-1:0]      z_hi_q;
    logic [BITS-1:0]      z_lo_q;

    alu_op_decoder #(
        .SIG_COUNT (SIG_COUNT),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .LAT_W     (LAT_W)
    ) u_dec (
        .op     (bus.op),
        .ctrl   (dec_ctrl),
        .latency(dec_latency),
        .illegal(dec_illegal)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            z_hi_q <= '0;
            z_lo_q <= '0;
            alu_x  <= '0;
            alu_y  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        alu_x  <= bus.a_in;
                        alu_y  <= bus.b_in;
                        ctrl_q <= dec_ctrl;
                        if (dec_illegal) begin
                            // Illegal op leaves Z untouched.
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else if (bus.op == OP_DIV && bus.b_in == '0) begin
                            err_q  <= 1'b1;
                            z_hi_q <= '0;
                            z_lo_q <= '0;
                            state  <= S_DONE;
                        end else begin
                            cnt   <= CNT_W'(dec_latency - LAT_W'(1));
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        z_hi_q <= alu_result[2*BITS-1:BITS];
                        z_lo_q <= alu_result[BITS-1:0];
                        err_q  <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        err_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alu_ctrl = (state == S_EXEC) ? ctrl_q : '0;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.err  = err_q;
    assign bus.z_hi = z_hi_q;
    assign bus.z_lo = z_lo_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU stub on the ALU side.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [12:0] alu_ctrl;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [63:0] alu_result;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    alu_seq_if #(.BITS(32)) bus ();

    alu_sequencer #(
        .BITS      (32),
        .SIG_COUNT (13),
        .MUL_CYCLES(4),
        .DIV_CYCLES(8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .alu_ctrl  (alu_ctrl),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_result(alu_result),
        .state     (state)
    );

    always #5 clk = ~clk;

    // ALU stub: result is zero whenever no control line is asserted.
    always_comb begin
        alu_result = '0;
        if (alu_ctrl[0])      alu_result = {32'd0, alu_x + alu_y};
        else if (alu_ctrl[1]) alu_result = {32'd0, alu_x - alu_y};
        else if (alu_ctrl[2]) alu_result = 64'(alu_x) * 64'(alu_y);
        else if (alu_ctrl[3] && alu_y != 32'd0) alu_result = {alu_x % alu_y, alu_x / alu_y};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ctrl"}, 64'(alu_ctrl), 64'd0);
        check({tag, "_x"},    64'(alu_x), 64'd0);
        check({tag, "_y"},    64'(alu_y), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"},  64'(bus.err), 64'd0);
        check({tag, "_zhi"},  64'(bus.z_hi), 64'd0);
        check({tag, "_zlo"},  64'(bus.z_lo), 64'd0);
        check({tag, "_st"},   64'(state), 64'd0);
    endtask

    task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    initial begin
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a_in  = 32'd0;
        bus.b_in  = 32'd0;
        bus.ack   = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        clr = 1'b1;
        tick();

        // add 5+7: one EXEC cycle, done held until ack
        do_start(4'd0, 32'd5, 32'd7);
        check("add_exec_ctrl", 64'(alu_ctrl), 64'h1);
        check("add_exec_busy", 64'(bus.busy), 64'd1);
        check("add_exec_done", 64'(bus.done), 64'd0);
        check("add_x", 64'(alu_x), 64'd5);
        check("add_y", 64'(alu_y), 64'd7);
        tick();
        check("add_done", 64'(bus.done), 64'd1);
        check("add_done_ctrl", 64'(alu_ctrl), 64'd0);
        check("add_zlo", 64'(bus.z_lo), 64'd12);
        check("add_zhi", 64'(bus.z_hi), 64'd0);
        check("add_err", 64'(bus.err), 64'd0);
        tick();
        check("add_done_held", 64'(bus.done), 64'd1);
        do_ack();
        check("add_ack_done", 64'(bus.done), 64'd0);
        check("add_ack_busy", 64'(bus.busy), 64'd0);

        // mul 0x10000*0x10000: four EXEC cycles
        do_start(4'd2, 32'h10000, 32'h10000);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul_ctrl%0d", i), 64'(alu_ctrl), 64'h4);
            check($sformatf("mul_nodone%0d", i), 64'(bus.done), 64'd0);
            tick();
        end
        check("mul_done", 64'(bus.done), 64'd1);
        check("mul_done_ctrl", 64'(alu_ctrl), 64'd0);
        check("mul_zhi", 64'(bus.z_hi), 64'd1);
        check("mul_zlo", 64'(bus.z_lo), 64'd0);
        do_ack();

        // divide by zero: straight to DONE, Z cleared
        do_start(4'd3, 32'd9, 32'd0);
        check("dz_done", 64'(bus.done), 64'd1);
        check("dz_err", 64'(bus.err), 64'd1);
        check("dz_ctrl", 64'(alu_ctrl), 64'd0);
        check("dz_zhi", 64'(bus.z_hi), 64'd0);
        check("dz_zlo", 64'(bus.z_lo), 64'd0);
        do_ack();

        // start during EXEC is ignored; mul 3*4 result returned
        do_start(4'd2, 32'd3, 32'd4);
        bus.start = 1'b1;
        bus.op    = 4'd0;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd200;
        tick();
        bus.start = 1'b0;
        check("ign_x", 64'(alu_x), 64'd3);
        check("ign_ctrl", 64'(alu_ctrl), 64'h4);
        tick();
        tick();
        tick();
        check("ign_done", 64'(bus.done), 64'd1);
        check("ign_zlo", 64'(bus.z_lo), 64'd12);
        check("ign_y", 64'(alu_y), 64'd4);
        do_ack();
        tick();
        check("ign_not_queued", 64'(bus.busy), 64'd0);

        // illegal op 13: error, Z keeps 12
        do_start(4'd13, 32'd1, 32'd1);
        check("ill_done", 64'(bus.done), 64'd1);
        check("ill_err", 64'(bus.err), 64'd1);
        check("ill_ctrl", 64'(alu_ctrl), 64'd0);
        check("ill_zlo", 64'(bus.z_lo), 64'd12);
        check("ill_st", 64'(state), 64'd2);
        do_ack();
        check("ill_ack_err", 64'(bus.err), 64'd0);

        // back-to-back sub 10-3 with start and ack held high
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        bus.op    = 4'd1;
        bus.a_in  = 32'd10;
        bus.b_in  = 32'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b2b_exec_ctrl%0d", i), 64'(alu_ctrl), 64'h2);
            check($sformatf("b2b_exec_done%0d", i), 64'(bus.done), 64'd0);
            tick();
            check($sformatf("b2b_done%0d", i), 64'(bus.done), 64'd1);
            check($sformatf("b2b_zlo%0d", i), 64'(bus.z_lo), 64'd7);
            tick();
            check($sformatf("b2b_idle%0d", i), 64'(bus.busy), 64'd0);
        end
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        tick();

        // reset in the second cycle of a divide
        do_start(4'd3, 32'd100, 32'd7);
        tick();
        check("rst_pre_ctrl", 64'(alu_ctrl), 64'h8);
        clr = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        tick();
        clr = 1'b1;
        tick();
        do_start(4'd0, 32'd5, 32'd7);
        tick();
        check("rst_add_done", 64'(bus.done), 64'd1);
        check("rst_add_zlo", 64'(bus.z_lo), 64'd12);
        check("rst_add_err", 64'(bus.err), 64'd0);
        do_ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
